// File: rtl/counter_if.sv
// counter_if: WIDTH-bit up/down counter with synchronous reset, parallel
// load, a combinational all-ones flag and a one-cycle registered wrap pulse.
module counter_if #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load,
  input  logic             down,
  output logic [WIDTH-1:0] count,
  output logic             rollover,
  output logic             wrap
);

  // Widths outside 1..32 are refused while the design is being elaborated.
  if (WIDTH < 1 || WIDTH > 32) begin : g_badWidth
    $error("counter_if: WIDTH must be in 1..32");
  end

  localparam logic [WIDTH-1:0] STEP = WIDTH'(1);

  logic [WIDTH-1:0] r_count;
  logic             r_wrap;
  logic             w_atMax;
  logic             w_atZero;
  logic             w_wrapNext;

  // A count step wraps when going up from all ones or down from zero.
  assign w_atMax    = &r_count;
  assign w_atZero   = (r_count == '0);
  assign w_wrapNext = down ? w_atZero : w_atMax;

  // Reset beats load, load beats counting; wrap only follows a real wrap step.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
      r_wrap  <= 1'b0;
    end else if (load_en) begin
      r_count <= load;
      r_wrap  <= 1'b0;
    end else if (down) begin
      r_count <= r_count - STEP;
      r_wrap  <= w_wrapNext;
    end else begin
      r_count <= r_count + STEP;
      r_wrap  <= w_wrapNext;
    end
  end

  assign count    = r_count;
  assign rollover = w_atMax;
  assign wrap     = r_wrap;

endmodule

// File: tb/tb_counter_if.sv
// tb_counter_if: directed self-checking bench for counter_if (WIDTH=4 and WIDTH=2).
module tb_counter_if;

  logic       clk = 1'b0;
  logic       rst;
  logic       loadEn;
  logic [3:0] load;
  logic       down;
  logic [3:0] count;
  logic       rollover;
  logic       wrap;

  logic       rst2;
  logic       loadEn2;
  logic [1:0] load2;
  logic       down2;
  logic [1:0] count2;
  logic       rollover2;
  logic       wrap2;

  int testCount = 0;
  int failCount = 0;

  counter_if #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .load_en(loadEn), .load(load), .down(down),
    .count(count), .rollover(rollover), .wrap(wrap)
  );

  counter_if #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst2), .load_en(loadEn2), .load(load2), .down(down2),
    .count(count2), .rollover(rollover2), .wrap(wrap2)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Drive one set of inputs away from the edge, then let one rising edge pass.
  task automatic applyStimulus(input logic r, input logic le, input logic [3:0] ld, input logic dn);
    @(negedge clk);
    rst = r;
    loadEn = le;
    load = ld;
    down = dn;
    @(posedge clk);
    #1;
  endtask

  // Compare the WIDTH=4 outputs {count, rollover, wrap} against expectations.
  task automatic checkOutput(input string tag, input logic [3:0] expCount,
                             input logic expRoll, input logic expWrap);
    testCount++;
    assert ({count, rollover, wrap} === {expCount, expRoll, expWrap}) else begin
      failCount++;
      $error("[TB] FAIL %s: got count=%h rollover=%b wrap=%b, expected count=%h rollover=%b wrap=%b",
             tag, count, rollover, wrap, expCount, expRoll, expWrap);
    end
  endtask

  // Compare the WIDTH=2 outputs.
  task automatic checkOutput2(input string tag, input logic [1:0] expCount,
                              input logic expRoll, input logic expWrap);
    testCount++;
    assert ({count2, rollover2, wrap2} === {expCount, expRoll, expWrap}) else begin
      failCount++;
      $error("[TB] FAIL %s: got count=%h rollover=%b wrap=%b, expected count=%h rollover=%b wrap=%b",
             tag, count2, rollover2, wrap2, expCount, expRoll, expWrap);
    end
  endtask

  // Guard against the run never finishing.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence with hand-computed expectations.
  initial begin
    logic [1:0] exp2Count [5];
    logic       exp2Roll  [5];
    logic       exp2Wrap  [5];
    exp2Count = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    exp2Roll  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    exp2Wrap  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    rst = 1'b1; loadEn = 1'b1; load = 4'hF; down = 1'b0;
    rst2 = 1'b1; loadEn2 = 1'b0; load2 = 2'd0; down2 = 1'b0;

    // Reset held with load requested: reset wins every edge.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b1, 4'hF, 1'b0);
      checkOutput($sformatf("reset_%0d", i), 4'h0, 1'b0, 1'b0);
    end
    checkOutput2("reset_w2", 2'd0, 1'b0, 1'b0);

    // Load beats down, then count down.
    applyStimulus(1'b0, 1'b1, 4'hD, 1'b1);
    checkOutput("load_D", 4'hD, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 4'hD, 1'b1);
    checkOutput("down_C", 4'hC, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 4'hD, 1'b1);
    checkOutput("down_B", 4'hB, 1'b0, 1'b0);

    // Up through all ones and wrap to zero.
    applyStimulus(1'b0, 1'b1, 4'hB, 1'b0);
    checkOutput("load_B", 4'hB, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b0);
    checkOutput("up_C", 4'hC, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b0);
    checkOutput("up_D", 4'hD, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b0);
    checkOutput("up_E", 4'hE, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b0);
    checkOutput("up_F", 4'hF, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b0);
    checkOutput("up_wrap_0", 4'h0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b0);
    checkOutput("up_after_wrap_1", 4'h1, 1'b0, 1'b0);

    // Down through zero and wrap to all ones.
    applyStimulus(1'b0, 1'b1, 4'h1, 1'b0);
    checkOutput("load_1", 4'h1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b1);
    checkOutput("down_0", 4'h0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b1);
    checkOutput("down_wrap_F", 4'hF, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b1);
    checkOutput("down_E", 4'hE, 1'b0, 1'b0);

    // Loads reaching all ones or zero never raise wrap.
    applyStimulus(1'b0, 1'b1, 4'hF, 1'b0);
    checkOutput("load_F", 4'hF, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 4'h0, 1'b0);
    checkOutput("load_0_from_F", 4'h0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 4'hF, 1'b0);
    checkOutput("reload_F", 4'hF, 1'b1, 1'b0);

    // Reset together with load: reset wins.
    applyStimulus(1'b1, 1'b1, 4'h7, 1'b0);
    checkOutput("rst_with_load", 4'h0, 1'b0, 1'b0);

    // Reset in the middle of counting, then resume from zero.
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b0);
    checkOutput("resume_1", 4'h1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b0);
    checkOutput("count_2", 4'h2, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 4'h0, 1'b0);
    checkOutput("mid_rst", 4'h0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b0);
    checkOutput("after_rst_1", 4'h1, 1'b0, 1'b0);

    // A load pulse that ends before the edge is not seen.
    @(negedge clk);
    loadEn = 1'b1; load = 4'h9;
    #2;
    loadEn = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("glitch_ignored", 4'h2, 1'b0, 1'b0);

    // WIDTH=2 instance counting up from reset through its wrap.
    rst = 1'b1;
    @(negedge clk);
    rst2 = 1'b0; loadEn2 = 1'b0; down2 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checkOutput2($sformatf("w2_up_%0d", i), exp2Count[i], exp2Roll[i], exp2Wrap[i]);
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/counter_if.md
COUNTER_IF -- requirements
Module: counter_if

Interface
REQ-001 Parameter WIDTH, default 4: counter width in bits; legal range 1..32; an out-of-range value SHALL be rejected at elaboration.
REQ-002 clk  input  1  clock; all state updates on rising edge; one clock domain only.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 load_en  input  1  when 1, count takes the value on load at the next edge.
REQ-005 load  input  WIDTH  parallel load value.
REQ-006 down  input  1  direction: 1 = decrement, 0 = increment.
REQ-007 count  output  WIDTH  current counter value, driven directly from a register.
REQ-008 rollover  output  1  combinational flag; 1 when count is all ones.
REQ-009 wrap  output  1  registered one-cycle pulse marking a modular wrap of count.

Function
REQ-010 Each rising clk edge SHALL apply the first matching rule, in this priority order: rst, load_en, down, up.
REQ-011 rst=1: count <= 0 and wrap <= 0, regardless of load_en, load and down.
REQ-012 rst=0, load_en=1: count <= load and wrap <= 0; down is ignored.
REQ-013 rst=0, load_en=0, down=1: count <= count - 1 modulo 2^WIDTH.
REQ-014 rst=0, load_en=0, down=0: count <= count + 1 modulo 2^WIDTH.
REQ-015 The counter SHALL count on every non-reset, non-load cycle; there is no separate enable.
REQ-016 Wrap-around, up: all ones -> 0; wrap <= 1 for exactly the following cycle.
REQ-017 Wrap-around, down: 0 -> all ones; wrap <= 1 for exactly the following cycle.
REQ-018 wrap <= 0 on every other edge, including any load that happens to produce 0 or all ones.
REQ-019 rollover = AND-reduction of count, with zero latency relative to count.
REQ-020 rollover is level-sensitive and SHALL be 1 whenever count is all ones, however that value was reached (load, count up or count down).
REQ-021 Latency: a change on load_en, load or down takes effect at the first rising edge after it.
REQ-022 Inputs SHALL be sampled only at the rising edge; input changes between edges have no effect.
REQ-023 Arithmetic is unsigned and exactly WIDTH bits; no carry, borrow or saturation output exists.
REQ-024 Simultaneous rst and load_en: rst wins. Simultaneous load_en and down: load wins.
REQ-025 rst asserted in the middle of counting SHALL zero count at the next edge.
REQ-026 After rst deasserts, counting resumes from 0 on the first edge with rst=0.
REQ-027 The design SHALL contain no latches, no asynchronous logic and no initial-value dependence.

Reset
REQ-028 rst is synchronous: it has no effect until a rising clk edge.
REQ-029 Values after the first reset edge: count=0, wrap=0, rollover=0 (because count is 0).
REQ-030 Until the first reset edge, output values are unspecified; the bench SHALL apply rst for at least 1 cycle, and 5 cycles is recommended.

Verification
REQ-031 rst=1 for 5 edges with load_en=1 and load=0xF -> count=0x0, rollover=0, wrap=0 throughout.
REQ-032 load_en=1, load=0xD, down=1 for 1 edge -> count=0xD; then load_en=0 for 2 edges -> 0xC, 0xB.
REQ-033 Load 0xB, then up for 5 edges -> 0xC, 0xD, 0xE, 0xF (rollover=1), 0x0 (rollover=0, wrap=1 for one cycle).
REQ-034 Load 0x1, then down for 3 edges -> 0x0, 0xF (wrap=1, rollover=1), 0xE (wrap=0, rollover=0).
REQ-035 Load 0xF -> rollover=1 and wrap=0; then rst=1 with load_en=1 on the same edge -> count=0.
REQ-036 WIDTH=2, up from 0 for 5 edges -> 1, 2, 3 (rollover=1), 0 (wrap=1), 1.
